acc_bcd_display: RTL
====================

# acc_bcd_display

Downstream display stage for the 8-bit add/subtract accumulator. It consumes the accumulator's registered sum and overflow flag and converts the sum to three BCD digits with a sequential shift-add-3 (double-dabble) engine. It drives four active-low seven-segment displays: ones, tens, hundreds, and a sign/overflow indicator. A conversion starts automatically whenever the observed inputs change.

## Interface
- BLANK_LZ, default 1: 1 blanks leading-zero hundreds/tens digits; 0 always shows all three digits.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- value  input  8  accumulator sum (S of the accumulator stage).
- ovf_in  input  1  accumulator overflow/carry flag.
- sign_mode  input  1  1: value is two's complement; 0: unsigned.
- bcd  output  12  last converted magnitude {hundreds, tens, ones}.
- hex0, hex1, hex2  output  7 each  ones, tens, hundreds digit segments, {g,f,e,d,c,b,a}, active-low.
- hex3  output  7  sign/overflow segments.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the outputs update.

## Operation
- Snapshot registers hold last_val, last_ovf, last_sign and a first flag; all are cleared by reset, and first=1.
- FSM states are IDLE, SHIFT and DONE.
- IDLE: at an edge where first=1 or any input differs from its snapshot:
  - capture all inputs into the snapshots and clear first;
  - compute the magnitude: if sign_mode=1 and value[7]=1, mag = (~value)+1 and neg=1; otherwise mag = value and neg=0;
  - clear the BCD shift register, set count=0, go to SHIFT.
- SHIFT: each edge, add 3 to every BCD nibble that is >=5, then shift {bcd, mag} left by one.
  - count increments; after the 8th shift, go to DONE.
- DONE: one edge that registers bcd, hex0-3 and done=1, then returns to IDLE.
- Input changes while busy are ignored, not lost. The snapshot comparison in IDLE detects them and starts a new conversion.
- Digit patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Blank is 1111111.
- Leading-zero blanking (BLANK_LZ=1):
  - hex2 is blank if hundreds=0;
  - hex1 is blank if hundreds=0 and tens=0;
  - hex0 always shows its digit.
- hex3 priority: captured ovf=1 shows 'E' (0000110); else neg=1 shows '-' (0111111); else blank.
- Signed 8'h80 converts to magnitude 128 with neg=1.

## Timing
- Reset values: hex0-3 = 7'b1111111, bcd=0, busy=0, done=0, state IDLE, first=1.
- Reset asserted mid-conversion aborts immediately. After release, the first edge starts a conversion of the current inputs.
- Latency: if the change is sampled at edge E0, SHIFT runs on edges E1-E8 and DONE on E9.
  - Outputs and done are valid after E9, 10 edges after detection.
  - busy is high from after E0 until after E9.
- done is high for exactly one cycle after E9 and is low otherwise.
- Back-to-back: the earliest next detection edge is E10.
- Display outputs hold their previous values throughout a conversion; there is no flicker.
- Stable inputs cause no further conversions; busy and done stay low.

## Test plan
- Reset with value=0 → all hex = 1111111 during reset. After release: done after 10 edges, hex0=1000000, hex1/hex2/hex3 blank, bcd=12'h000.
- Unsigned value=255, sign_mode=0 → bcd=12'h255, hex2=0100100, hex1=0010010, hex0=0010010, hex3 blank, busy high for exactly 9 cycles.
- sign_mode=1, value=8'hF6 → bcd=12'h010, hex3=0111111, hex1=1111001, hex0=1000000, hex2 blank. With BLANK_LZ=0, hex2=1000000.
- value 8'd12 changed to 8'd99 at E4 of a conversion → done after E9 shows bcd=12'h012. A second conversion is detected at E10 and done after E19 shows bcd=12'h099.
- ovf_in=1 with sign_mode=1, value=8'h80 → bcd=12'h128, hex3=0000110 ('E' overrides '-').
- rst_n pulsed low at E5 of a conversion of 8'd77 → busy=0 and hex blank immediately. After release, bcd=12'h077 is reached 10 edges later.

Source files
------------

// File: rtl/acc_bcd_display.sv
// Display stage for the 8-bit accumulator: a sequential double-dabble converter
// drives three BCD digits and a sign/overflow digit on active-low 7-segment outputs.
module acc_bcd_display #(
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  value,
   input  logic        ovf_in,
   input  logic        sign_mode,
   output logic [11:0] bcd,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic        busy,
   output logic        done,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;

   state_t      state_q;
   logic        first_q;
   logic [7:0]  last_val_q;
   logic        last_ovf_q;
   logic        last_sign_q;
   logic [7:0]  mag_q;
   logic        neg_q;
   logic        ovf_q;
   logic [11:0] shreg_q;
   logic [2:0]  cnt_q;
   logic [11:0] bcd_q;
   logic [6:0]  hex0_q, hex1_q, hex2_q, hex3_q;
   logic        busy_q, done_q;

   logic        changed;
   logic [11:0] adj;
   logic [19:0] shift_d;
   logic [6:0]  hex0_d, hex1_d, hex2_d, hex3_d;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   function automatic logic [3:0] add3(input logic [3:0] n);
      add3 = (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   assign changed = first_q || (value != last_val_q) || (ovf_in != last_ovf_q)
                    || (sign_mode != last_sign_q);

   // Correct every nibble before the shift, then move one magnitude bit in.
   assign adj     = {add3(shreg_q[11:8]), add3(shreg_q[7:4]), add3(shreg_q[3:0])};
   assign shift_d = {adj[10:0], mag_q, 1'b0};

   always_comb begin
      hex0_d = seg7(shreg_q[3:0]);
      hex1_d = seg7(shreg_q[7:4]);
      hex2_d = seg7(shreg_q[11:8]);
      hex3_d = SEG_BLANK;
      if (BLANK_LZ && shreg_q[11:8] == 4'd0) begin
         hex2_d = SEG_BLANK;
         if (shreg_q[7:4] == 4'd0) hex1_d = SEG_BLANK;
      end
      if (ovf_q)      hex3_d = SEG_E;
      else if (neg_q) hex3_d = SEG_MINUS;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         first_q     <= 1'b1;
         last_val_q  <= 8'd0;
         last_ovf_q  <= 1'b0;
         last_sign_q <= 1'b0;
         mag_q       <= 8'd0;
         neg_q       <= 1'b0;
         ovf_q       <= 1'b0;
         shreg_q     <= 12'd0;
         cnt_q       <= 3'd0;
         bcd_q       <= 12'd0;
         hex0_q      <= SEG_BLANK;
         hex1_q      <= SEG_BLANK;
         hex2_q      <= SEG_BLANK;
         hex3_q      <= SEG_BLANK;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (changed) begin
                  first_q     <= 1'b0;
                  last_val_q  <= value;
                  last_ovf_q  <= ovf_in;
                  last_sign_q <= sign_mode;
                  mag_q       <= (sign_mode && value[7]) ? (~value + 8'd1) : value;
                  neg_q       <= sign_mode && value[7];
                  ovf_q       <= ovf_in;
                  shreg_q     <= 12'd0;
                  cnt_q       <= 3'd0;
                  busy_q      <= 1'b1;
                  state_q     <= SHIFT;
               end
            end
            SHIFT: begin
               {shreg_q, mag_q} <= shift_d;
               cnt_q            <= cnt_q + 3'd1;
               if (cnt_q == 3'd7) state_q <= DONE;
            end
            DONE: begin
               bcd_q   <= shreg_q;
               hex0_q  <= hex0_d;
               hex1_q  <= hex1_d;
               hex2_q  <= hex2_d;
               hex3_q  <= hex3_d;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bcd         = bcd_q;
   assign hex0        = hex0_q;
   assign hex1        = hex1_q;
   assign hex2        = hex2_q;
   assign hex3        = hex3_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign dbg_state_o = state_q;

endmodule
